// File: rtl/axi_lite_mem_arbiter_pkg.sv
// Shared types for the AXI4-Lite memory arbiter: FSM encoding and AXI response codes.
package axi_lite_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AR,
        ST_R,
        ST_WA,
        ST_B
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'd0;
    localparam logic [1:0] RESP_EXOKAY = 2'd1;
    localparam logic [1:0] RESP_SLVERR = 2'd2;
    localparam logic [1:0] RESP_DECERR = 2'd3;

endpackage

// File: rtl/axi_lite_mem_arbiter_if.sv
// AXI4-Lite bus bundle; master modport faces the arbiter, slave modport faces the interconnect.
interface axi_lite_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic [2:0]            awprot;
    logic                  awvalid;
    logic                  awready;
    logic [DATA_WIDTH-1:0] wdata;
    logic [STRB_WIDTH-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input  bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input  rdata, rresp, rvalid, output rready
    );

    modport slave (
        input  awaddr, awprot, awvalid, output awready,
        input  wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input  araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );

endinterface

// File: rtl/axi_lite_mem_arbiter_rr_arbiter.sv
// Combinational grant picker: round-robin starting after ptr, or lowest-index-wins when fixed.
module axi_lite_mem_arbiter_rr_arbiter #(
    parameter int NUM_PORTS      = 2,
    parameter int FIXED_PRIORITY = 0,
    parameter int IDX_W          = 1
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt_oh,
    output logic [IDX_W-1:0]     gnt_idx,
    output logic                 gnt_any
);
    logic [IDX_W-1:0] k;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        k       = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            k = (FIXED_PRIORITY != 0) ? IDX_W'(i)
                                      : IDX_W'((int'(ptr) + 1 + i) % NUM_PORTS);
            if (!gnt_any && req[k]) begin
                gnt_any    = 1'b1;
                gnt_oh[k]  = 1'b1;
                gnt_idx    = k;
            end
        end
    end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// N-requester AXI4-Lite master: arbitrates clients and runs one transaction at a time,
// returning rdata/resp with a one-cycle done pulse to the granted port.
module axi_lite_mem_arbiter
    import axi_lite_mem_arbiter_pkg::*;
#(
    parameter int NUM_PORTS      = 2,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int FIXED_PRIORITY = 0
) (
    input  logic                            CLK,
    input  logic                            RST,
    input  logic [NUM_PORTS-1:0]            req,
    input  logic [NUM_PORTS-1:0]            req_we,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_wdata,
    input  logic [NUM_PORTS*(DATA_WIDTH/8)-1:0] req_wstrb,
    output logic [NUM_PORTS-1:0]            done,
    output logic [DATA_WIDTH-1:0]           rdata,
    output logic [1:0]                      resp,
    axi_lite_mem_arbiter_if.master          m_axi
);
    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int IDX_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] addr_a;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] wdata_a;
    logic [NUM_PORTS-1:0][STRB_WIDTH-1:0] wstrb_a;

    assign addr_a  = req_addr;
    assign wdata_a = req_wdata;
    assign wstrb_a = req_wstrb;

    state_e                state;
    logic [IDX_W-1:0]      rr_ptr;
    logic [NUM_PORTS-1:0]  gnt_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_WIDTH-1:0] wstrb_q;
    logic                  arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;

    logic [NUM_PORTS-1:0]  gnt_oh;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  gnt_any;

    axi_lite_mem_arbiter_rr_arbiter #(
        .NUM_PORTS      (NUM_PORTS),
        .FIXED_PRIORITY (FIXED_PRIORITY),
        .IDX_W          (IDX_W)
    ) u_arb (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt_oh  (gnt_oh),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // A valid is considered finished once it is low or handshaking this cycle.
    logic aw_fin, w_fin;
    assign aw_fin = !awvalid_q || m_axi.awready;
    assign w_fin  = !wvalid_q  || m_axi.wready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            rr_ptr    <= IDX_W'(NUM_PORTS - 1);
            gnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            done      <= '0;
            rdata     <= '0;
            resp      <= RESP_OKAY;
        end else begin
            done <= '0;
            case (state)
                ST_IDLE: if (gnt_any) begin
                    rr_ptr  <= gnt_idx;
                    gnt_q   <= gnt_oh;
                    addr_q  <= addr_a[gnt_idx];
                    wdata_q <= wdata_a[gnt_idx];
                    wstrb_q <= wstrb_a[gnt_idx];
                    if (req_we[gnt_idx]) begin
                        awvalid_q <= 1'b1;
                        wvalid_q  <= 1'b1;
                        state     <= ST_WA;
                    end else begin
                        arvalid_q <= 1'b1;
                        state     <= ST_AR;
                    end
                end
                ST_AR: if (m_axi.arready) begin
                    arvalid_q <= 1'b0;
                    rready_q  <= 1'b1;
                    state     <= ST_R;
                end
                ST_R: if (m_axi.rvalid) begin
                    rready_q <= 1'b0;
                    rdata    <= m_axi.rdata;
                    resp     <= m_axi.rresp;
                    done     <= gnt_q;
                    state    <= ST_IDLE;
                end
                ST_WA: begin
                    if (awvalid_q && m_axi.awready) awvalid_q <= 1'b0;
                    if (wvalid_q && m_axi.wready)   wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state    <= ST_B;
                    end
                end
                ST_B: if (m_axi.bvalid) begin
                    bready_q <= 1'b0;
                    resp     <= m_axi.bresp;
                    done     <= gnt_q;
                    state    <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign m_axi.araddr  = addr_q;
    assign m_axi.arprot  = 3'b000;
    assign m_axi.arvalid = arvalid_q;
    assign m_axi.rready  = rready_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awprot  = 3'b000;
    assign m_axi.awvalid = awvalid_q;
    assign m_axi.wdata   = wdata_q;
    assign m_axi.wstrb   = wstrb_q;
    assign m_axi.wvalid  = wvalid_q;
    assign m_axi.bready  = bready_q;

endmodule

// File: tb/tb_axi_lite_mem_arbiter.sv
// Directed bench: a round-robin instance with a scriptable slave and a fixed-priority
// instance with an always-ready slave.
module tb_axi_lite_mem_arbiter;
    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // round-robin instance
    logic [NP-1:0]    rr_req = '0, rr_we = '0;
    logic [NP*AW-1:0] rr_addr = '0;
    logic [NP*DW-1:0] rr_wdata = '0;
    logic [NP*SW-1:0] rr_wstrb = '0;
    logic [NP-1:0]    rr_done;
    logic [DW-1:0]    rr_rdata;
    logic [1:0]       rr_resp;

    logic          auto_slv = 1'b0;
    logic          s_arready = 1'b0, s_awready = 1'b0, s_wready = 1'b0;
    logic          s_rvalid = 1'b0, s_bvalid = 1'b0;
    logic [DW-1:0] s_rdata = '0;
    logic [1:0]    s_rresp = '0, s_bresp = '0;

    axi_lite_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) rr_if ();

    assign rr_if.arready = auto_slv | s_arready;
    assign rr_if.awready = auto_slv | s_awready;
    assign rr_if.wready  = auto_slv | s_wready;
    assign rr_if.rvalid  = auto_slv ? rr_if.rready : s_rvalid;
    assign rr_if.bvalid  = auto_slv ? rr_if.bready : s_bvalid;
    assign rr_if.rdata   = s_rdata;
    assign rr_if.rresp   = s_rresp;
    assign rr_if.bresp   = s_bresp;

    axi_lite_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(0)
    ) u_rr (
        .CLK(CLK), .RST(RST),
        .req(rr_req), .req_we(rr_we), .req_addr(rr_addr),
        .req_wdata(rr_wdata), .req_wstrb(rr_wstrb),
        .done(rr_done), .rdata(rr_rdata), .resp(rr_resp),
        .m_axi(rr_if)
    );

    // fixed-priority instance, zero-wait slave
    logic [NP-1:0]    fp_req = '0, fp_we = '0;
    logic [NP*AW-1:0] fp_addr = '0;
    logic [NP*DW-1:0] fp_wdata = '0;
    logic [NP*SW-1:0] fp_wstrb = '0;
    logic [NP-1:0]    fp_done;
    logic [DW-1:0]    fp_rdata;
    logic [1:0]       fp_resp;

    axi_lite_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) fp_if ();

    assign fp_if.arready = 1'b1;
    assign fp_if.awready = 1'b1;
    assign fp_if.wready  = 1'b1;
    assign fp_if.rvalid  = fp_if.rready;
    assign fp_if.bvalid  = fp_if.bready;
    assign fp_if.rdata   = 32'hF00D_0000;
    assign fp_if.rresp   = 2'd0;
    assign fp_if.bresp   = 2'd0;

    axi_lite_mem_arbiter #(
        .NUM_PORTS(NP), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIXED_PRIORITY(1)
    ) u_fp (
        .CLK(CLK), .RST(RST),
        .req(fp_req), .req_we(fp_we), .req_addr(fp_addr),
        .req_wdata(fp_wdata), .req_wstrb(fp_wstrb),
        .done(fp_done), .rdata(fp_rdata), .resp(fp_resp),
        .m_axi(fp_if)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bounded wait for the next done pulse; returns 0 on timeout.
    task automatic wait_done(input bit fp, output logic [NP-1:0] d);
        d = '0;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if ((fp ? fp_done : rr_done) != '0) begin
                d = fp ? fp_done : rr_done;
                break;
            end
        end
    endtask

    logic [NP-1:0] d;
    logic [NP-1:0] rr_exp [4];

    initial begin
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100; rr_exp[3] = 3'b001;

        // reset state
        repeat (2) @(negedge CLK);
        chk("rst_valids", 64'({rr_if.arvalid, rr_if.awvalid, rr_if.wvalid, rr_if.rready, rr_if.bready}), 64'(0));
        chk("rst_done", 64'(rr_done), 64'(0));
        chk("rst_rdata_resp", 64'({rr_rdata, rr_resp}), 64'(0));
        RST = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("idle_valid", 64'({rr_if.arvalid, rr_if.awvalid}), 64'(0));
        end

        // single read, port 0
        rr_addr[0 +: AW] = 32'hABAC;
        rr_req = 3'b001;
        @(negedge CLK);
        chk("rd_arvalid", 64'(rr_if.arvalid), 64'(1));
        chk("rd_araddr", 64'(rr_if.araddr), 64'h ABAC);
        chk("rd_arprot", 64'(rr_if.arprot), 64'(0));
        s_arready = 1'b1;
        @(negedge CLK);
        chk("rd_ar_drop_rready", 64'({rr_if.arvalid, rr_if.rready}), 64'b01);
        chk("rd_no_early_done", 64'(rr_done), 64'(0));
        s_arready = 1'b0;
        s_rvalid  = 1'b1;
        s_rdata   = 32'hDEAD_AAAA;
        s_rresp   = 2'd0;
        @(negedge CLK);
        chk("rd_done", 64'(rr_done), 64'b001);
        chk("rd_rdata", 64'(rr_rdata), 64'h DEAD_AAAA);
        chk("rd_resp", 64'(rr_resp), 64'(0));
        chk("rd_rready_drop", 64'(rr_if.rready), 64'(0));
        rr_req   = '0;
        s_rvalid = 1'b0;
        @(negedge CLK);
        chk("rd_done_1cyc", 64'(rr_done), 64'(0));

        // write port 1, W accepted two cycles before AW, SLVERR
        rr_req = 3'b010;
        rr_we  = 3'b010;
        rr_addr[AW +: AW]   = 32'h100;
        rr_wdata[DW +: DW]  = 32'h1234_5678;
        rr_wstrb[SW +: SW]  = 4'b0011;
        @(negedge CLK);
        chk("wr_valids", 64'({rr_if.awvalid, rr_if.wvalid}), 64'b11);
        chk("wr_awaddr", 64'(rr_if.awaddr), 64'h100);
        chk("wr_wdata", 64'(rr_if.wdata), 64'h1234_5678);
        chk("wr_wstrb", 64'(rr_if.wstrb), 64'b0011);
        s_wready = 1'b1;
        @(negedge CLK);
        chk("wr_w_first", 64'({rr_if.awvalid, rr_if.wvalid}), 64'b10);
        s_wready = 1'b0;
        @(negedge CLK);
        chk("wr_aw_wait", 64'({rr_if.awvalid, rr_if.wvalid, rr_if.bready}), 64'b100);
        chk("wr_awaddr_stable", 64'(rr_if.awaddr), 64'h100);
        s_awready = 1'b1;
        @(negedge CLK);
        chk("wr_bready", 64'({rr_if.awvalid, rr_if.wvalid, rr_if.bready}), 64'b001);
        s_awready = 1'b0;
        s_bvalid  = 1'b1;
        s_bresp   = 2'd2;
        @(negedge CLK);
        chk("wr_done", 64'(rr_done), 64'b010);
        chk("wr_resp", 64'(rr_resp), 64'd2);
        chk("wr_rdata_kept", 64'(rr_rdata), 64'h DEAD_AAAA);
        rr_req   = '0;
        rr_we    = '0;
        s_bvalid = 1'b0;
        s_bresp  = 2'd0;
        @(negedge CLK);

        // reset during R state
        rr_addr[0 +: AW] = 32'h40;
        rr_req = 3'b001;
        @(negedge CLK);
        s_arready = 1'b1;
        @(negedge CLK);
        s_arready = 1'b0;
        chk("mr_in_r", 64'(rr_if.rready), 64'(1));
        #2 RST = 1'b1;
        #1;
        chk("mr_rready_async", 64'(rr_if.rready), 64'(0));
        chk("mr_no_done", 64'(rr_done), 64'(0));
        rr_req = '0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        chk("mr_idle_after", 64'({rr_done, rr_if.arvalid, rr_if.rready}), 64'(0));

        // next request completes normally (port 2, zero-wait slave)
        auto_slv = 1'b1;
        s_rdata  = 32'h5555_AAAA;
        rr_addr[2*AW +: AW] = 32'h200;
        rr_req = 3'b100;
        wait_done(1'b0, d);
        chk("mr_next_done", 64'(d), 64'b100);
        chk("mr_next_rdata", 64'(rr_rdata), 64'h5555_AAAA);
        rr_req = '0;
        @(negedge CLK);

        // round-robin fairness with all ports held (pointer left at port 2)
        rr_req = 3'b111;
        for (int k = 0; k < 4; k++) begin
            wait_done(1'b0, d);
            chk("rr_order", 64'(d), 64'(rr_exp[k]));
        end
        rr_req = '0;
        repeat (6) @(negedge CLK);

        // fixed priority: port 0 starves port 2 until it drops
        fp_req = 3'b101;
        for (int k = 0; k < 3; k++) begin
            wait_done(1'b1, d);
            chk("fp_port0_wins", 64'(d), 64'b001);
        end
        chk("fp_rdata", 64'(fp_rdata), 64'h F00D_0000);
        fp_req = 3'b100;
        wait_done(1'b1, d);
        chk("fp_port2_after", 64'(d), 64'b100);
        fp_req = '0;
        repeat (3) @(negedge CLK);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

endmodule
